tlb_cache: RTL and testbench

Parametrised, fully associative instruction/data address-translation cache. It is the successor to the fixed 16-entry, 4 KB-page translation block.
- Translates a virtual address to a physical address.
- Runs an explicit miss/refill handshake with the page walker.
- Replaces entries round-robin.
- Supports a flush.
- Sits between the fetch/LSU request port and the page-walk unit.

---
 rtl/tlb_cache_if.sv | 44 ++++
 rtl/tlb_cache.sv | 213 +++++++++++++++++++++
 tb/tb_tlb_cache.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_cache_if.sv
// ---------------------------------------------------------------------------
// tlb_cache_if
// Purpose : Bundles the two sides of the translation cache into one interface.
//           The first side is the request/response port to fetch/LSU. The
//           second side is the miss/refill handshake with the page walker.
// Modports:
//   slave  - the translation cache itself.
//            Inputs : req_valid, req_vaddr, walk_resp_valid, walk_resp_ok,
//                     walk_resp_ppn.
//            Outputs: req_ready, resp_valid, resp_paddr, resp_hit,
//                     resp_fault, walk_req_valid, walk_vpn.
//   master - the environment, i.e. the requester and the walker (the
//            mirror image of slave).
// ---------------------------------------------------------------------------
interface tlb_cache_if #(
    parameter int VA_W      = 32,
    parameter int PA_W      = 32,
    parameter int PAGE_BITS = 12
);
    logic                      req_valid;
    logic [VA_W-1:0]           req_vaddr;
    logic                      req_ready;
    logic                      resp_valid;
    logic [PA_W-1:0]           resp_paddr;
    logic                      resp_hit;
    logic                      resp_fault;
    logic                      walk_req_valid;
    logic [VA_W-PAGE_BITS-1:0] walk_vpn;
    logic                      walk_resp_valid;
    logic                      walk_resp_ok;
    logic [PA_W-PAGE_BITS-1:0] walk_resp_ppn;

    modport slave (
        input  req_valid, req_vaddr, walk_resp_valid, walk_resp_ok, walk_resp_ppn,
        output req_ready, resp_valid, resp_paddr, resp_hit, resp_fault,
               walk_req_valid, walk_vpn
    );

    modport master (
        output req_valid, req_vaddr, walk_resp_valid, walk_resp_ok, walk_resp_ppn,
        input  req_ready, resp_valid, resp_paddr, resp_hit, resp_fault,
               walk_req_valid, walk_vpn
    );
endinterface

// File: rtl/tlb_cache.sv
// ---------------------------------------------------------------------------
// tlb_cache
// Purpose : Fully associative address-translation cache.
//           - A hit answers one cycle after the request is accepted.
//           - A miss asks the page walker for a translation, and a successful
//             walk is written into the entry chosen round-robin.
//           - Flush invalidates every entry.
// Ports   :
//   clk        - clock, rising edge.
//   rst        - asynchronous reset, active low.
//   bus        - tlb_cache_if.slave. Carries the request/response port and
//                the walker handshake.
//   flush      - invalidate all entries and reset the replacement pointer.
//   victim_idx - current replacement pointer (debug).
//   stat_hits, stat_misses - 32-bit accepted hit/miss counters. These ports
//                exist only when the macro TLB_STATS_EN is defined.
// Optional: TLB_STATS_EN adds the statistics counters. The counters are
//           cleared by reset only; flush does not clear them.
// ---------------------------------------------------------------------------
module tlb_cache #(
    parameter int VA_W      = 32,
    parameter int PA_W      = 32,
    parameter int PAGE_BITS = 12,
    parameter int ENTRIES   = 16,
    parameter int IDX_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    tlb_cache_if.slave       bus,
    input  logic             flush,
    output logic [IDX_W-1:0] victim_idx
`ifdef TLB_STATS_EN
    ,
    output logic [31:0]      stat_hits,
    output logic [31:0]      stat_misses
`endif
);
    localparam int VPN_W = VA_W - PAGE_BITS;
    localparam int PPN_W = PA_W - PAGE_BITS;

    typedef enum logic [1:0] {S_IDLE, S_WALK, S_RESP} state_e;

    state_e             state_q, state_d;
    logic [VA_W-1:0]    vaddr_q, vaddr_d;
    logic [IDX_W-1:0]   victim_q, victim_d;
    logic               flush_pend_q, flush_pend_d;
    logic [PA_W-1:0]    resp_paddr_q, resp_paddr_d;
    logic               resp_hit_q, resp_hit_d;
    logic               resp_fault_q, resp_fault_d;
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [VPN_W-1:0]   vpn_q [ENTRIES];
    logic [VPN_W-1:0]   vpn_d [ENTRIES];
    logic [PPN_W-1:0]   ppn_q [ENTRIES];
    logic [PPN_W-1:0]   ppn_d [ENTRIES];

    // ---------------- combinational lookup ----------------
    logic [VPN_W-1:0]   req_vpn;
    logic [ENTRIES-1:0] match;
    logic               lookup_hit;
    logic [IDX_W-1:0]   hit_idx;
    logic               refill_we;

    assign req_vpn = bus.req_vaddr[VA_W-1:PAGE_BITS];

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_match
            assign match[gi] = valid_q[gi] && (vpn_q[gi] == req_vpn);
        end
    endgenerate

    // Scan from the top down so that the lowest matching index is written last.
    always_comb begin
        lookup_hit = |match;
        hit_idx    = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (match[i]) hit_idx = IDX_W'(i);
        end
    end

    // ---------------- next state / datapath ----------------
    always_comb begin
        state_d      = state_q;
        vaddr_d      = vaddr_q;
        victim_d     = victim_q;
        flush_pend_d = flush_pend_q;
        resp_paddr_d = resp_paddr_q;
        resp_hit_d   = resp_hit_q;
        resp_fault_d = resp_fault_q;
        valid_d      = valid_q;
        vpn_d        = vpn_q;
        ppn_d        = ppn_q;
        refill_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && !flush) begin
                    vaddr_d = bus.req_vaddr;
                    if (lookup_hit) begin
                        state_d      = S_RESP;
                        resp_paddr_d = {ppn_q[hit_idx], bus.req_vaddr[PAGE_BITS-1:0]};
                        resp_hit_d   = 1'b1;
                        resp_fault_d = 1'b0;
                    end else begin
                        state_d = S_WALK;
                    end
                end
            end
            S_WALK: begin
                if (bus.walk_resp_valid) begin
                    state_d    = S_RESP;
                    resp_hit_d = 1'b0;
                    if (bus.walk_resp_ok) begin
                        // A flush this cycle or earlier in the walk makes
                        // the translation stale, so it is still returned
                        // but is not cached.
                        refill_we    = !flush && !flush_pend_q;
                        resp_paddr_d = {bus.walk_resp_ppn, vaddr_q[PAGE_BITS-1:0]};
                        resp_fault_d = 1'b0;
                    end else begin
                        resp_paddr_d = '0;
                        resp_fault_d = 1'b1;
                    end
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (refill_we) begin
            valid_d[victim_q] = 1'b1;
            vpn_d[victim_q]   = vaddr_q[VA_W-1:PAGE_BITS];
            ppn_d[victim_q]   = bus.walk_resp_ppn;
            victim_d = (victim_q == IDX_W'(ENTRIES - 1)) ? '0 : victim_q + 1'b1;
        end

        if (state_q == S_RESP)
            flush_pend_d = 1'b0;
        else if (flush && state_q == S_WALK)
            flush_pend_d = 1'b1;

        if (flush) begin
            valid_d  = '0;
            victim_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            vaddr_q      <= '0;
            victim_q     <= '0;
            flush_pend_q <= 1'b0;
            resp_paddr_q <= '0;
            resp_hit_q   <= 1'b0;
            resp_fault_q <= 1'b0;
            valid_q      <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                vpn_q[i] <= '0;
                ppn_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            vaddr_q      <= vaddr_d;
            victim_q     <= victim_d;
            flush_pend_q <= flush_pend_d;
            resp_paddr_q <= resp_paddr_d;
            resp_hit_q   <= resp_hit_d;
            resp_fault_q <= resp_fault_d;
            valid_q      <= valid_d;
            vpn_q        <= vpn_d;
            ppn_q        <= ppn_d;
        end
    end

    // req_ready is gated with rst so that it stays low while reset is held.
    assign bus.req_ready      = rst && (state_q == S_IDLE) && !flush;
    assign bus.resp_valid     = (state_q == S_RESP);
    assign bus.resp_paddr     = resp_paddr_q;
    assign bus.resp_hit       = resp_hit_q;
    assign bus.resp_fault     = resp_fault_q;
    assign bus.walk_req_valid = (state_q == S_WALK);
    assign bus.walk_vpn       = (state_q == S_WALK) ? vaddr_q[VA_W-1:PAGE_BITS] : '0;
    assign victim_idx         = victim_q;

`ifdef TLB_STATS_EN
    logic [31:0] hits_q, hits_d, misses_q, misses_d;
    logic        accept_c;

    always_comb begin
        accept_c = (state_q == S_IDLE) && bus.req_valid && !flush;
        hits_d   = hits_q;
        misses_d = misses_q;
        if (accept_c) begin
            if (lookup_hit) hits_d   = hits_q + 32'd1;
            else            misses_d = misses_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            hits_q   <= hits_d;
            misses_q <= misses_d;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`endif
endmodule

// File: tb/tb_tlb_cache.sv
module tb_tlb_cache;
    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [3:0] victim_idx;
`ifdef TLB_STATS_EN
    logic [31:0] stat_hits, stat_misses;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tlb_cache_if bus ();

    tlb_cache dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .flush      (flush),
        .victim_idx (victim_idx)
`ifdef TLB_STATS_EN
        ,
        .stat_hits  (stat_hits),
        .stat_misses(stat_misses)
`endif
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [31:0] va);
        bus.req_valid = 1'b1;
        bus.req_vaddr = va;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic answer_walk(input logic ok, input logic [19:0] ppn, input int delay);
        repeat (delay) tick();
        bus.walk_resp_valid = 1'b1;
        bus.walk_resp_ok    = ok;
        bus.walk_resp_ppn   = ppn;
        tick();
        bus.walk_resp_valid = 1'b0;
        bus.walk_resp_ok    = 1'b0;
    endtask

    task automatic show(input string tag);
        $display("txn %s: vaddr=%h resp_valid=%b paddr=%h hit=%b fault=%b victim=%0d",
                 tag, bus.req_vaddr, bus.resp_valid, bus.resp_paddr, bus.resp_hit,
                 bus.resp_fault, victim_idx);
    endtask

    task automatic test_reset;
        rst = 1'b0; flush = 1'b0;
        bus.req_valid = 1'b0; bus.req_vaddr = '0;
        bus.walk_resp_valid = 1'b0; bus.walk_resp_ok = 1'b0; bus.walk_resp_ppn = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_low: got %b want 0", bus.req_ready); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
        checks++; if (bus.walk_req_valid !== 1'b0) begin errors++; $display("FAIL rst_walk_req: got %b want 0", bus.walk_req_valid); end
        checks++; if (bus.resp_paddr !== 32'h0) begin errors++; $display("FAIL rst_paddr: got %h want 0", bus.resp_paddr); end
        checks++; if (victim_idx !== 4'd0) begin errors++; $display("FAIL rst_victim: got %0d want 0", victim_idx); end
        rst = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_release: got %b want 1", bus.req_ready); end
        $display("txn reset: released, req_ready=%b", bus.req_ready);
    endtask

    task automatic test_refill;
        send_req(32'h0040_1234);
        checks++; if (bus.walk_req_valid !== 1'b1) begin errors++; $display("FAIL refill_walk_req: got %b want 1", bus.walk_req_valid); end
        checks++; if (bus.walk_vpn !== 20'h00401) begin errors++; $display("FAIL refill_walk_vpn: got %h want 00401", bus.walk_vpn); end
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL refill_ready_walk: got %b want 0", bus.req_ready); end
        repeat (3) begin
            tick();
            checks++; if (bus.walk_vpn !== 20'h00401) begin errors++; $display("FAIL refill_vpn_stable: got %h want 00401", bus.walk_vpn); end
        end
        answer_walk(1'b1, 20'h12345, 0);
        show("refill");
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL refill_resp_valid: got %b want 1", bus.resp_valid); end
        checks++; if (bus.resp_paddr !== 32'h1234_5234) begin errors++; $display("FAIL refill_paddr: got %h want 12345234", bus.resp_paddr); end
        checks++; if (bus.resp_hit !== 1'b0) begin errors++; $display("FAIL refill_hit: got %b want 0", bus.resp_hit); end
        checks++; if (bus.walk_req_valid !== 1'b0) begin errors++; $display("FAIL refill_walk_drop: got %b want 0", bus.walk_req_valid); end
        checks++; if (victim_idx !== 4'd1) begin errors++; $display("FAIL refill_victim: got %0d want 1", victim_idx); end
        tick();
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL refill_one_cycle: got %b want 0", bus.resp_valid); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL refill_ready_back: got %b want 1", bus.req_ready); end
    endtask

    task automatic test_hit;
        send_req(32'h0040_1ABC);
        show("hit");
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL hit_resp_valid: got %b want 1", bus.resp_valid); end
        checks++; if (bus.resp_paddr !== 32'h1234_5ABC) begin errors++; $display("FAIL hit_paddr: got %h want 12345abc", bus.resp_paddr); end
        checks++; if (bus.resp_hit !== 1'b1) begin errors++; $display("FAIL hit_flag: got %b want 1", bus.resp_hit); end
        checks++; if (bus.walk_req_valid !== 1'b0) begin errors++; $display("FAIL hit_no_walk: got %b want 0", bus.walk_req_valid); end
        checks++; if (victim_idx !== 4'd1) begin errors++; $display("FAIL hit_victim: got %0d want 1", victim_idx); end
        tick();
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL hit_one_cycle: got %b want 0", bus.resp_valid); end
    endtask

    task automatic test_stray_walk;
        bus.walk_resp_valid = 1'b1; bus.walk_resp_ok = 1'b1; bus.walk_resp_ppn = 20'h77777;
        tick();
        bus.walk_resp_valid = 1'b0; bus.walk_resp_ok = 1'b0;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL stray_resp: got %b want 0", bus.resp_valid); end
        checks++; if (victim_idx !== 4'd1) begin errors++; $display("FAIL stray_victim: got %0d want 1", victim_idx); end
        send_req(32'h0040_1000);
        show("stray_then_hit");
        checks++; if (bus.resp_paddr !== 32'h1234_5000) begin errors++; $display("FAIL stray_entry_intact: got %h want 12345000", bus.resp_paddr); end
        tick();
    endtask

    task automatic test_fault;
        send_req(32'h8000_0000);
        checks++; if (bus.walk_vpn !== 20'h80000) begin errors++; $display("FAIL fault_vpn: got %h want 80000", bus.walk_vpn); end
        answer_walk(1'b0, 20'h0, 1);
        show("fault");
        checks++; if (bus.resp_fault !== 1'b1) begin errors++; $display("FAIL fault_flag: got %b want 1", bus.resp_fault); end
        checks++; if (bus.resp_paddr !== 32'h0) begin errors++; $display("FAIL fault_paddr: got %h want 0", bus.resp_paddr); end
        checks++; if (bus.resp_hit !== 1'b0) begin errors++; $display("FAIL fault_hit: got %b want 0", bus.resp_hit); end
        checks++; if (victim_idx !== 4'd1) begin errors++; $display("FAIL fault_victim: got %0d want 1", victim_idx); end
        tick();
        send_req(32'h8000_0000);
        checks++; if (bus.walk_req_valid !== 1'b1) begin errors++; $display("FAIL fault_remiss: got %b want 1", bus.walk_req_valid); end
        answer_walk(1'b0, 20'h0, 0);
        show("fault_again");
        tick();
    endtask

    task automatic test_wrap;
        flush = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", bus.req_ready); end
        tick();
        flush = 1'b0;
        checks++; if (victim_idx !== 4'd0) begin errors++; $display("FAIL flush_victim: got %0d want 0", victim_idx); end
        send_req(32'h0040_1ABC);
        checks++; if (bus.walk_req_valid !== 1'b1) begin errors++; $display("FAIL flush_miss: got %b want 1", bus.walk_req_valid); end
        answer_walk(1'b0, 20'h0, 0);
        tick();
        for (int k = 0; k < 17; k++) begin
            send_req({20'h10000 + 20'(k), 12'(k)});
            answer_walk(1'b1, 20'h20000 + 20'(k), 0);
            show("fill");
            checks++; if (bus.resp_paddr !== {20'h20000 + 20'(k), 12'(k)}) begin errors++; $display("FAIL fill_paddr k=%0d: got %h want %h", k, bus.resp_paddr, {20'h20000 + 20'(k), 12'(k)}); end
            checks++; if (victim_idx !== 4'((k + 1) % 16)) begin errors++; $display("FAIL fill_victim k=%0d: got %0d want %0d", k, victim_idx, (k + 1) % 16); end
            tick();
        end
        send_req(32'h1000_2055);
        show("wrap_p2");
        checks++; if (bus.resp_hit !== 1'b1) begin errors++; $display("FAIL wrap_p2_hit: got %b want 1", bus.resp_hit); end
        checks++; if (bus.resp_paddr !== 32'h2000_2055) begin errors++; $display("FAIL wrap_p2_paddr: got %h want 20002055", bus.resp_paddr); end
        tick();
        send_req(32'h1001_0000);
        checks++; if (bus.resp_paddr !== 32'h2001_0000) begin errors++; $display("FAIL wrap_p16_paddr: got %h want 20010000", bus.resp_paddr); end
        tick();
        send_req(32'h1000_0000);
        checks++; if (bus.walk_req_valid !== 1'b1) begin errors++; $display("FAIL wrap_p0_evicted: got %b want 1", bus.walk_req_valid); end
        answer_walk(1'b0, 20'h0, 0);
        show("wrap_p0");
        tick();
    endtask

    task automatic test_flush_walk;
        send_req(32'h0055_5000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (bus.walk_req_valid !== 1'b1) begin errors++; $display("FAIL fwalk_still_walking: got %b want 1", bus.walk_req_valid); end
        checks++; if (victim_idx !== 4'd0) begin errors++; $display("FAIL fwalk_victim_reset: got %0d want 0", victim_idx); end
        answer_walk(1'b1, 20'h0AAAA, 1);
        show("flush_walk");
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL fwalk_resp: got %b want 1", bus.resp_valid); end
        checks++; if (bus.resp_paddr !== 32'h0AAA_A000) begin errors++; $display("FAIL fwalk_paddr: got %h want 0aaaa000", bus.resp_paddr); end
        checks++; if (victim_idx !== 4'd0) begin errors++; $display("FAIL fwalk_no_write: got %0d want 0", victim_idx); end
        tick();
        send_req(32'h0055_5010);
        checks++; if (bus.walk_req_valid !== 1'b1) begin errors++; $display("FAIL fwalk_remiss: got %b want 1", bus.walk_req_valid); end
        answer_walk(1'b1, 20'h0AAAA, 0);
        checks++; if (victim_idx !== 4'd1) begin errors++; $display("FAIL fwalk_refill_after: got %0d want 1", victim_idx); end
        tick();
        // flush in the same cycle as the refill answer
        send_req(32'h0066_6000);
        bus.walk_resp_valid = 1'b1; bus.walk_resp_ok = 1'b1; bus.walk_resp_ppn = 20'h0BBBB;
        flush = 1'b1;
        tick();
        bus.walk_resp_valid = 1'b0; bus.walk_resp_ok = 1'b0; flush = 1'b0;
        show("flush_coincident");
        checks++; if (bus.resp_paddr !== 32'h0BBB_B000) begin errors++; $display("FAIL fco_paddr: got %h want 0bbbb000", bus.resp_paddr); end
        checks++; if (victim_idx !== 4'd0) begin errors++; $display("FAIL fco_victim: got %0d want 0", victim_idx); end
        tick();
        send_req(32'h0066_6000);
        checks++; if (bus.walk_req_valid !== 1'b1) begin errors++; $display("FAIL fco_remiss: got %b want 1", bus.walk_req_valid); end
        answer_walk(1'b1, 20'h0BBBB, 0);
        checks++; if (victim_idx !== 4'd1) begin errors++; $display("FAIL fco_refill_after: got %0d want 1", victim_idx); end
        tick();
    endtask

    task automatic test_back_to_back;
        bus.req_valid = 1'b1;
        bus.req_vaddr = 32'h0066_6ABC;
        tick();
        show("b2b_1");
        checks++; if (bus.resp_paddr !== 32'h0BBB_BABC) begin errors++; $display("FAIL b2b_paddr1: got %h want 0bbbbabc", bus.resp_paddr); end
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_resp: got %b want 0", bus.req_ready); end
        bus.req_vaddr = 32'h0066_6DEF;
        tick();
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap: got %b want 0", bus.resp_valid); end
        tick();
        bus.req_valid = 1'b0;
        show("b2b_2");
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL b2b_resp2: got %b want 1", bus.resp_valid); end
        checks++; if (bus.resp_paddr !== 32'h0BBB_BDEF) begin errors++; $display("FAIL b2b_paddr2: got %h want 0bbbbdef", bus.resp_paddr); end
        tick();
    endtask

    task automatic test_reset_midwalk;
        send_req(32'h0077_7000);
        checks++; if (bus.walk_req_valid !== 1'b1) begin errors++; $display("FAIL rmw_walk: got %b want 1", bus.walk_req_valid); end
        rst = 1'b0;
        #1;
        checks++; if (bus.walk_req_valid !== 1'b0) begin errors++; $display("FAIL rmw_async_drop: got %b want 0", bus.walk_req_valid); end
        checks++; if (victim_idx !== 4'd0) begin errors++; $display("FAIL rmw_victim: got %0d want 0", victim_idx); end
`ifdef TLB_STATS_EN
        checks++; if (stat_hits !== 32'd0) begin errors++; $display("FAIL rmw_stat_hits: got %0d want 0", stat_hits); end
        checks++; if (stat_misses !== 32'd0) begin errors++; $display("FAIL rmw_stat_misses: got %0d want 0", stat_misses); end
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rmw_ready: got %b want 1", bus.req_ready); end
        send_req(32'h0066_6ABC);
        checks++; if (bus.walk_req_valid !== 1'b1) begin errors++; $display("FAIL rmw_entries_cleared: got %b want 1", bus.walk_req_valid); end
        answer_walk(1'b0, 20'h0, 0);
        show("reset_midwalk");
        tick();
`ifdef TLB_STATS_EN
        checks++; if (stat_misses !== 32'd1) begin errors++; $display("FAIL rmw_stat_count: got %0d want 1", stat_misses); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_refill();
        test_hit();
        test_stray_walk();
        test_fault();
        test_wrap();
        test_flush_walk();
        test_back_to_back();
        test_reset_midwalk();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
